// File: rtl/tinyodin_pkg.sv
// Shared constants and FSM state type for the tinyODIN spike encoder slice.
package tinyodin_pkg;

  localparam int unsigned N_DEF          = 256;
  localparam int unsigned M_DEF          = 8;
  localparam int unsigned INPUT_RESO_DEF = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } enc_state_e;

endpackage

// File: rtl/spike_fifo.sv
// Spike index FIFO: registered read data, pointers carry an extra wrap bit.
module spike_fifo
  import tinyodin_pkg::*;
#(
  parameter int unsigned W     = M_DEF,
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_data_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] rd_data_q, rd_data_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign pop_data_o = rd_data_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    mem_d     = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data_i;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
      rd_ptr_d  = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage is not reset; pointers alone define valid contents.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/spike_encoder.sv
// Rate-based spike encoder: per-channel accumulators overflow into a spike FIFO.
module spike_encoder
  import tinyodin_pkg::*;
#(
  parameter int unsigned N          = N_DEF,
  parameter int unsigned M          = M_DEF,
  parameter int unsigned INPUT_RESO = INPUT_RESO_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  start_i,
  input  logic                  next_tick_i,
  input  logic [M-1:0]          max_input_i,
  input  logic                  in_we_i,
  input  logic [M-1:0]          in_addr_i,
  input  logic [INPUT_RESO-1:0] in_data_i,
  input  logic                  fifo_r_en_i,
  output logic [M-1:0]          fifo_r_data_o,
  output logic                  fifo_empty_o,
  output logic                  fifo_full_o,
  output logic                  spikecore_done_o,
  output logic                  overrun_o
);

  enc_state_e            state_q, state_d;
  logic [M-1:0]          idx_q, idx_d;
  logic                  overrun_q, overrun_d;
  logic [INPUT_RESO-1:0] int_q [N];
  logic [INPUT_RESO-1:0] int_d [N];
  logic [INPUT_RESO-1:0] acc_q [N];
  logic [INPUT_RESO-1:0] acc_d [N];
  logic [INPUT_RESO:0]   sum;
  logic                  push;

  assign spikecore_done_o = (state_q == DONE);
  assign overrun_o        = overrun_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    acc_d     = acc_q;
    int_d     = int_q;
    push      = 1'b0;
    sum       = {1'b0, acc_q[idx_q]} + {1'b0, int_q[idx_q]};

    if (in_we_i) int_d[in_addr_i] = in_data_i;

    // Dropping start_i overrides every state transition and leaves data intact.
    if (!start_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = SCAN;
          idx_d     = '0;
          overrun_d = 1'b0;
          acc_d     = '{default: '0};
        end
        SCAN: begin
          if (next_tick_i) overrun_d = 1'b1;
          if (!fifo_full_o) begin
            acc_d[idx_q] = sum[INPUT_RESO-1:0];
            push         = sum[INPUT_RESO];
            if (idx_q == max_input_i) state_d = DONE;
            else                      idx_d   = idx_q + 1'b1;
          end
        end
        DONE: begin
          if (next_tick_i) begin
            state_d = SCAN;
            idx_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      acc_q     <= '{default: '0};
      int_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      acc_q     <= acc_d;
      int_q     <= int_d;
    end
  end

  spike_fifo #(
    .W     (M),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .push_i      (push),
    .push_data_i (idx_q),
    .pop_i       (fifo_r_en_i),
    .pop_data_o  (fifo_r_data_o),
    .empty_o     (fifo_empty_o),
    .full_o      (fifo_full_o)
  );

endmodule

// File: doc/spike_encoder.md
SPIKE_ENCODER -- requirements
Module: spike_encoder

Interface
REQ-001 SHALL have parameter N, default 256, number of input channels.
REQ-002 SHALL have parameter M, default 8, index width (log2 N).
REQ-003 SHALL have parameter INPUT_RESO, default 8, intensity and accumulator width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 256, spike FIFO entries (power of two, at least 2).
REQ-005 SHALL have ports CLK input 1 (clock) and RSTN input 1 (reset, asynchronous, active-low).
REQ-006 SHALL have start_i input 1: run enable from the controller.
REQ-007 SHALL have next_tick_i input 1: single-cycle tick pulse.
REQ-008 SHALL have max_input_i input M: last channel index scanned.
REQ-009 SHALL have in_we_i input 1, in_addr_i input M and in_data_i input INPUT_RESO: intensity write port.
REQ-010 SHALL have fifo_r_en_i input 1, fifo_r_data_o output M, fifo_empty_o output 1 and fifo_full_o output 1: spike FIFO read side.
REQ-011 SHALL have spikecore_done_o output 1: scan of the current tick complete.
REQ-012 SHALL have overrun_o output 1: sticky flag, tick arrived during a scan.

Function
REQ-013 SHALL use FSM states IDLE, SCAN and DONE.
REQ-014 SHALL go IDLE->SCAN when start_i=1: scan index reset to 0, all accumulators cleared to 0.
REQ-015 SHALL, in SCAN, process one channel per cycle unless fifo_full_o=1; when full, stall with index and accumulators held.
REQ-016 SHALL compute per channel i: sum = acc[i] + int[i] at INPUT_RESO+1 bits; acc[i] <= sum[INPUT_RESO-1:0]; carry=1 pushes i into the FIFO in the same cycle.
REQ-017 SHALL go SCAN->DONE after channel max_input_i is processed; max_input_i=0 scans channel 0 only.
REQ-018 SHALL drive spikecore_done_o=1 only in DONE, combinationally from state.
REQ-019 SHALL go DONE->SCAN on next_tick_i=1, index 0, accumulators retained.
REQ-020 SHALL ignore next_tick_i in SCAN except to set overrun_o; overrun_o clears only on RSTN or on the IDLE->SCAN transition.
REQ-021 SHALL go from any state to IDLE within one cycle when start_i=0; FIFO contents and accumulators are kept, and done drops.
REQ-022 SHALL accept intensity writes in every state, effective from the next cycle; a scan reads the value held in the register on that scan cycle.
REQ-023 SHALL make fifo_r_data_o registered: on an edge with fifo_r_en_i=1 and fifo_empty_o=0 it loads the head entry; otherwise it holds.
REQ-024 SHALL ignore pop-when-empty: data, pointers and flags unchanged.
REQ-025 SHALL, on simultaneous push and pop, perform both with occupancy unchanged; on pop at full, the stall releases next cycle.
REQ-026 SHALL have an empty-FIFO push visible as fifo_empty_o=0 the next cycle; no read-through.
REQ-027 SHALL wrap pointers modulo FIFO_DEPTH; occupancy is tracked with an extra MSB so full and empty are distinguished.
REQ-028 SHALL never produce a spike for intensity 0; intensity 2^INPUT_RESO-1 produces 255 spikes per 256 ticks at the default.

Reset
REQ-029 SHALL reset as follows: state IDLE; index, accumulators, intensities and pointers 0; fifo_r_data_o 0; fifo_empty_o 1; fifo_full_o 0; spikecore_done_o 0; overrun_o 0.
REQ-030 SHALL, on RSTN asserted mid-scan, abort the scan and discard all pending spikes.

Structure
REQ-031 SHALL place the FSM state enum and the default N, M, INPUT_RESO and FIFO_DEPTH constants in shared package tinyodin_pkg.
REQ-032 SHALL implement the FIFO as sub-module spike_fifo (push, pop, registered read data, empty and full flags).

Verification
REQ-033 SHALL verify: int[3]=128, max_input=7, start, 4 ticks -> channel 3 is pushed on ticks 2 and 4 only, and done asserts 8 cycles after each scan begins.
REQ-034 SHALL verify: int[0..7]=255, max_input=7 -> first scan pushes nothing; the second scan pushes 0..7 in order; pops return 0..7 and then empty=1.
REQ-035 SHALL verify: FIFO_DEPTH=4, int[0..7]=128, max_input=7, two ticks, no pops -> full after 4 pushes and the scan stalls; 4 pops resume it and done follows.
REQ-036 SHALL verify: push and pop in the same cycle at occupancy 2 -> occupancy stays 2 and the popped value is the oldest.
REQ-037 SHALL verify: next_tick_i during SCAN -> overrun_o=1, the scan completes normally, and the flag clears on restart.
REQ-038 SHALL verify: RSTN low during SCAN -> all outputs at reset values the same cycle, FIFO empty, and no spikes after release until start.
